req_queue: RTL and testbench
============================

Name: req_queue

Overview:
- Per-requester ingress buffering placed directly upstream of the round-robin arbiter.
- Holds N independent FIFOs of W-bit payloads.
- Drives the arbiter's req vector from FIFO occupancy.
- Consumes the arbiter's registered one-hot grant, popping the granted channel's head onto a single registered output stream tagged with channel id.

Parameters:
- N, 4, number of requester channels; must match the arbiter's N.
- W, 8, payload width in bits.
- DEPTH, 4, entries per channel FIFO; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk; 0 = reset.
- in_valid  in  N  per-channel push request.
- in_ready  out  N  per-channel space available.
- in_data  in  N*W  per-channel payload; channel i occupies bits [i*W +: W].
- req  out  N  to arbiter; channel i has an entry not already claimed by the current grant.
- grant  in  N  from arbiter; one-hot or zero; registered there, arrives one cycle after req sampled.
- out_valid  out  1  registered; popped entry present this cycle.
- out_data  out  W  registered; popped payload.
- out_id  out  $clog2(N)  registered; index of source channel.
- grant_err  out  1  sticky; set on grant to an empty channel or a non-one-hot grant.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All FIFO counts and pointers go to 0.
  - out_valid=0, out_data=0, out_id=0, grant_err=0.
  - in_ready is all-ones immediately after reset; req is all-zeros.
  - Reset mid-operation discards all buffered entries; no output is produced for them.
- Push: channel i accepts in_data[i] when in_valid[i] && in_ready[i]. in_ready[i] = (count[i] != DEPTH), combinational from count only, with no full-bypass on a simultaneous pop.
- Pop: channel i pops its head at the edge where grant[i]==1 and count[i]!=0.
- Push and pop on the same channel in the same cycle: count is unchanged and both pointers advance. With DEPTH>=2 this is legal at any non-full, non-empty count.
- req[i] = ((count[i] - grant[i]) != 0), combinational. This masks the entry being popped this cycle. Without the mask, the arbiter would regrant a channel holding a single entry one cycle after it drained.
- Output latency: the head popped at edge E appears on out_data/out_id with out_valid=1 in the cycle following E. out_valid=0 on any cycle following an edge with no pop.
- The output has no backpressure; the downstream consumer must accept every out_valid beat.
- Error handling:
  - Grant to an empty channel: no pop, out_valid=0, grant_err set.
  - grant with more than one bit set: no pop on any channel, out_valid=0, grant_err set.
  - grant_err clears only on reset.
- Pointer wrap: read/write pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Channels are fully independent; full or empty on one channel never affects another.

Decomposition:
- Shared package req_queue_pkg:
  - localparams ID_W=$clog2(N) and PTR_W=$clog2(DEPTH).
  - A function onehot_or_zero(grant) used for the error check.
- One natural sub-module: req_fifo, a single-channel synchronous FIFO.
  - Ports: clk, reset, push, push_data, pop, head_data, count.
  - Instantiated N times with a generate loop.
- The top level holds the req masking, the grant decode/mux, the output registers and grant_err.

Test Plan (N=4, W=8, DEPTH=4):
- Reset: hold reset=0 for 2 cycles mid-traffic with 3 entries on ch1 -> in_ready=4'b1111, req=0, out_valid=0, grant_err=0; ch1 entries never emitted.
- Single entry: push 8'hA5 on ch2, drive grant=4'b0100 one cycle later -> req[2] drops to 0 during the grant cycle; next cycle out_valid=1, out_data=8'hA5, out_id=2; no second grant needed.
- Fill to full: push 5 beats 8'h10..8'h14 on ch0 -> in_ready[0]=0 after the 4th; 8'h14 not accepted. Grant ch0 four times -> outputs 8'h10..8'h13 in order; count returns to 0.
- Simultaneous push and pop: ch3 holds 2 entries; push 8'h33 while grant=4'b1000 -> count stays 2, popped value is the oldest, 8'h33 emerges after the remaining entry.
- Pointer wrap: push/pop 10 entries on ch1 with occupancy cycling 1..3 -> values emerge in exact push order across the pointer wrap.
- Errors: grant=4'b0010 with ch1 empty, then grant=4'b0011 with both channels non-empty -> no pop, out_valid=0, grant_err=1 and held; counts unchanged.

Source files
------------

// File: rtl/req_queue_pkg.sv
// -----------------------------------------------------------------------------
// req_queue_pkg
// Shared configuration and helpers for the req_queue ingress buffer.
//   REQ_N      : number of requester channels (must match the arbiter)
//   REQ_W      : payload width in bits
//   REQ_DEPTH  : entries per channel FIFO (power of two, >= 2)
//   ID_W       : width of the channel id on the output stream
//   PTR_W      : FIFO read/write pointer width; counts are PTR_W+1 bits
//   onehot_or_zero() : grant sanity check used for grant_err
// Modules take N/W/DEPTH parameters defaulting to these values; ID_W and
// PTR_W are derived here, so any override must be made in this package.
// -----------------------------------------------------------------------------
package req_queue_pkg;

  localparam int REQ_N       = 4;
  localparam int REQ_W       = 8;
  localparam int REQ_DEPTH   = 4;
  localparam int ID_W        = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam int PTR_W       = $clog2(REQ_DEPTH);
  localparam int GRANT_MAX_W = 32;

  // True when at most one bit of v is set (clearing the lowest set bit
  // leaves nothing behind).
  function automatic logic onehot_or_zero(input logic [GRANT_MAX_W-1:0] v);
    return ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/req_queue_if.sv
// -----------------------------------------------------------------------------
// req_queue_if
// Bundle of the ingress, arbiter and egress signals of req_queue.
//   in_valid/in_ready/in_data : per-channel push side (channel i at [i*W +: W])
//   req/grant                 : to/from the round-robin arbiter
//   out_valid/out_data/out_id : registered single output stream
//   grant_err                 : sticky protocol error flag
// Modports: slave = req_queue itself, master = the surrounding logic.
// -----------------------------------------------------------------------------
interface req_queue_if #(
  parameter int N = req_queue_pkg::REQ_N,
  parameter int W = req_queue_pkg::REQ_W
) ();
  import req_queue_pkg::*;

  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    req;
  logic [N-1:0]    grant;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic [ID_W-1:0] out_id;
  logic            grant_err;

  modport slave (
    input  in_valid, in_data, grant,
    output in_ready, req, out_valid, out_data, out_id, grant_err
  );

  modport master (
    output in_valid, in_data, grant,
    input  in_ready, req, out_valid, out_data, out_id, grant_err
  );

endinterface

// File: rtl/req_fifo.sv
// -----------------------------------------------------------------------------
// req_fifo
// Single-channel synchronous FIFO with a combinational head read.
//   clk       : rising-edge clock
//   reset     : synchronous, active-low
//   push      : write push_data (ignored when full)
//   push_data : payload to store
//   pop       : drop the head entry (ignored when empty)
//   head_data : oldest stored entry
//   count     : occupancy, 0..DEPTH
// Push and pop in the same cycle advance both pointers and keep count.
// -----------------------------------------------------------------------------
module req_fifo import req_queue_pkg::*; #(
  parameter int W     = REQ_W,
  parameter int DEPTH = REQ_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic [W-1:0]   push_data,
  input  logic           pop,
  output logic [W-1:0]   head_data,
  output logic [PTR_W:0] count
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push    = push && (r_count != CNT_FULL);
  assign w_pop     = pop && (r_count != {(PTR_W+1){1'b0}});
  assign head_data = r_mem[r_rd_ptr];
  assign count     = r_count;

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {W{1'b0}};
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1'b1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/req_queue.sv
// -----------------------------------------------------------------------------
// req_queue
// Per-requester ingress buffering in front of a round-robin arbiter.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : req_queue_if.slave
//     in_valid/in_ready/in_data : per-channel push; in_ready = not full
//     req                       : channel holds an entry not claimed by grant
//     grant                     : registered one-hot (or zero) arbiter grant
//     out_valid/out_data/out_id : popped head, one cycle after the grant edge
//     grant_err                 : sticky; grant to empty channel or multi-hot
// The output stream has no backpressure.
// -----------------------------------------------------------------------------
module req_queue import req_queue_pkg::*; #(
  parameter int N     = REQ_N,
  parameter int W     = REQ_W,
  parameter int DEPTH = REQ_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  req_queue_if.slave  bus
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [W-1:0]    w_head  [N];
  logic [PTR_W:0]  w_count [N];
  logic [N-1:0]    w_nonempty;
  logic [N-1:0]    w_ready;
  logic [N-1:0]    w_req;
  logic [N-1:0]    w_push;
  logic [N-1:0]    w_pop;
  logic            w_grant_ok;
  logic            w_bad_grant;
  logic [W-1:0]    w_sel_data;
  logic [ID_W-1:0] w_sel_id;

  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic [ID_W-1:0] r_out_id;
  logic            r_grant_err;

  assign w_grant_ok  = onehot_or_zero(GRANT_MAX_W'(bus.grant));
  // Multi-hot grants are rejected outright; a one-hot grant must hit data.
  assign w_bad_grant = !w_grant_ok || ((bus.grant & ~w_nonempty) != {N{1'b0}});

  for (genvar ch = 0; ch < N; ch++) begin : g_ch
    assign w_nonempty[ch] = (w_count[ch] != {(PTR_W+1){1'b0}});
    assign w_ready[ch]    = (w_count[ch] != CNT_FULL);
    assign w_push[ch]     = bus.in_valid[ch] && w_ready[ch];
    assign w_pop[ch]      = w_grant_ok && bus.grant[ch] && w_nonempty[ch];
    // The entry being popped this cycle is already claimed; without this the
    // arbiter would regrant a single-entry channel right after it drained.
    // Compared as count > grant so an (erroneous) grant on an empty channel
    // cannot wrap around and raise a request.
    assign w_req[ch]      = (w_count[ch] > {{PTR_W{1'b0}}, bus.grant[ch]});

    req_fifo #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push[ch]),
      .push_data (bus.in_data[ch*W +: W]),
      .pop       (w_pop[ch]),
      .head_data (w_head[ch]),
      .count     (w_count[ch])
    );
  end

  assign bus.in_ready = w_ready;
  assign bus.req      = w_req;

  // AND-OR mux of the popped head; w_pop is one-hot or zero by construction.
  always_comb begin
    w_sel_data = {W{1'b0}};
    w_sel_id   = {ID_W{1'b0}};
    for (int i = 0; i < N; i++) begin
      w_sel_data = w_sel_data | ({W{w_pop[i]}} & w_head[i]);
      w_sel_id   = w_sel_id | ({ID_W{w_pop[i]}} & ID_W'(i));
    end
  end

  // Registered output stream and sticky grant error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {W{1'b0}};
      r_out_id    <= {ID_W{1'b0}};
      r_grant_err <= 1'b0;
    end else begin
      r_out_valid <= (w_pop != {N{1'b0}});
      if (w_pop != {N{1'b0}}) begin
        r_out_data <= w_sel_data;
        r_out_id   <= w_sel_id;
      end
      if (w_bad_grant) begin
        r_grant_err <= 1'b1;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign bus.grant_err = r_grant_err;

endmodule

// File: tb/tb_req_queue.sv
// -----------------------------------------------------------------------------
// tb_req_queue
// Self-checking bench for req_queue (N=4, W=8, DEPTH=4). A per-channel queue
// model predicts in_ready/req and the popped entries; popped entries go to a
// scoreboard queue that is drained as the DUT emits out_valid beats.
// -----------------------------------------------------------------------------
module tb_req_queue;
  import req_queue_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  g;
    logic [3:0]  rdy;
    logic [3:0]  rq;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  oid;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] id;
  } exp_t;

  typedef logic [7:0] byte_q_t[$];

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  int      n_checks = 0;
  int      n_fail = 0;
  byte_q_t mdl [N];
  exp_t    exp_q [$];
  logic    mdl_err = 1'b0;
  vec_t    tbl [13];

  always #5 clk = ~clk;

  req_queue_if #(.N(N), .W(W)) bus ();

  req_queue #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
    vec_t t;
    t = '{default: '0};
    t.v = v;
    t.d = d;
    t.g = g;
    return t;
  endfunction

  // One clock cycle: drive, check combinational outputs, update model,
  // clock edge, check registered outputs against model/scoreboard/table.
  task automatic step(input logic r, input vec_t t, input bit use_t);
    logic [3:0] rdy;
    logic [3:0] rq;
    logic       exp_ov;
    int         gi;
    exp_t       e;
    reset        = r;
    bus.in_valid = t.v;
    bus.in_data  = t.d;
    bus.grant    = t.g;
    for (int i = 0; i < N; i++) begin
      rdy[i] = (mdl[i].size() != DEPTH);
      rq[i]  = ((mdl[i].size() - int'(t.g[i])) > 0);
    end
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(rdy));
    chk("req", 32'(bus.req), 32'(rq));
    if (use_t) begin
      chk("tbl_in_ready", 32'(bus.in_ready), 32'(t.rdy));
      chk("tbl_req", 32'(bus.req), 32'(t.rq));
    end
    exp_ov = 1'b0;
    if (!r) begin
      for (int i = 0; i < N; i++) mdl[i].delete();
      exp_q.delete();
      mdl_err = 1'b0;
    end else begin
      gi = 0;
      for (int i = 0; i < N; i++) if (t.g[i]) gi = i;
      if ($countones(t.g) == 1) begin
        if (mdl[gi].size() != 0) begin
          e.d  = mdl[gi].pop_front();
          e.id = 2'(gi);
          exp_q.push_back(e);
          exp_ov = 1'b1;
        end else begin
          mdl_err = 1'b1;
        end
      end else if (t.g != 4'b0000) begin
        mdl_err = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (t.v[i] && rdy[i]) mdl[i].push_back(t.d[i*8 +: 8]);
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_out: actual=beat %0h required=no beat", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(e.d));
        chk("out_id", 32'(bus.out_id), 32'(e.id));
      end
    end
    chk("grant_err", 32'(bus.grant_err), 32'(mdl_err));
    if (use_t) begin
      chk("tbl_out_valid", 32'(bus.out_valid), 32'(t.ov));
      if (t.ov) begin
        chk("tbl_out_data", 32'(bus.out_data), 32'(t.od));
        chk("tbl_out_id", 32'(bus.out_id), 32'(t.oid));
      end
    end
  endtask

  initial begin
    int         pushed;
    int         occ;
    logic       pv;
    logic       pg;
    logic [7:0] val;

    // Single entry on ch2, then fill ch0 to full and drain it.
    //           v        d              g        rdy      rq       ov    od     oid
    tbl[0]  = '{4'b0100, 32'h00A5_0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0};
    tbl[1]  = '{4'b0000, 32'h0000_0000, 4'b0100, 4'b1111, 4'b0000, 1'b1, 8'hA5, 2'd2};
    tbl[2]  = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0};
    tbl[3]  = '{4'b0001, 32'h0000_0010, 4'b0000, 4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0};
    tbl[4]  = '{4'b0001, 32'h0000_0011, 4'b0000, 4'b1111, 4'b0001, 1'b0, 8'h00, 2'd0};
    tbl[5]  = '{4'b0001, 32'h0000_0012, 4'b0000, 4'b1111, 4'b0001, 1'b0, 8'h00, 2'd0};
    tbl[6]  = '{4'b0001, 32'h0000_0013, 4'b0000, 4'b1111, 4'b0001, 1'b0, 8'h00, 2'd0};
    tbl[7]  = '{4'b0001, 32'h0000_0014, 4'b0000, 4'b1110, 4'b0001, 1'b0, 8'h00, 2'd0};
    tbl[8]  = '{4'b0000, 32'h0000_0000, 4'b0001, 4'b1110, 4'b0001, 1'b1, 8'h10, 2'd0};
    tbl[9]  = '{4'b0000, 32'h0000_0000, 4'b0001, 4'b1111, 4'b0001, 1'b1, 8'h11, 2'd0};
    tbl[10] = '{4'b0000, 32'h0000_0000, 4'b0001, 4'b1111, 4'b0001, 1'b1, 8'h12, 2'd0};
    tbl[11] = '{4'b0000, 32'h0000_0000, 4'b0001, 4'b1111, 4'b0000, 1'b1, 8'h13, 2'd0};
    tbl[12] = '{4'b0000, 32'h0000_0000, 4'b0000, 4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0};

    // Power-on reset.
    bus.in_valid = 4'b0000;
    bus.in_data  = 32'h0;
    bus.grant    = 4'b0000;
    reset        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0000_000F);
    chk("rst_req", 32'(bus.req), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_id", 32'(bus.out_id), 32'h0);
    chk("rst_grant_err", 32'(bus.grant_err), 32'h0);

    for (int i = 0; i < 13; i++) step(1'b1, tbl[i], 1'b1);

    // Simultaneous push and pop on ch3 holding two entries.
    step(1'b1, mk(4'b1000, 32'h3000_0000, 4'b0000), 1'b0);
    step(1'b1, mk(4'b1000, 32'h3100_0000, 4'b0000), 1'b0);
    step(1'b1, mk(4'b1000, 32'h3300_0000, 4'b1000), 1'b0);
    step(1'b1, mk(4'b0000, 32'h0, 4'b1000), 1'b0);
    step(1'b1, mk(4'b0000, 32'h0, 4'b1000), 1'b0);
    step(1'b1, mk(4'b0000, 32'h0, 4'b0000), 1'b0);

    // Pointer wrap: ten entries through ch1 with mixed push/pop overlap.
    pushed = 0;
    for (int c = 0; c < 40; c++) begin
      occ = mdl[1].size();
      if (pushed == 10 && occ == 0) break;
      pv  = (pushed < 10) && (occ < 3);
      pg  = (occ == 3) || (pushed == 10 && occ > 0) || ((c % 3) == 2 && occ > 0);
      val = 8'(8'h40 + pushed);
      step(1'b1, mk({2'b00, pv, 1'b0}, {16'h0, val, 8'h00}, {2'b00, pg, 1'b0}), 1'b0);
      if (pv) pushed++;
    end
    chk("wrap_all_emitted", 32'(exp_q.size()), 32'h0);
    chk("wrap_count", 32'(pushed), 32'd10);

    // Grant errors: empty channel, then multi-hot with both channels loaded.
    step(1'b1, mk(4'b0000, 32'h0, 4'b0010), 1'b0);
    step(1'b1, mk(4'b0011, 32'h0000_5150, 4'b0000), 1'b0);
    step(1'b1, mk(4'b0000, 32'h0, 4'b0011), 1'b0);
    step(1'b1, mk(4'b0000, 32'h0, 4'b0000), 1'b0);
    step(1'b1, mk(4'b0000, 32'h0, 4'b0001), 1'b0);
    step(1'b1, mk(4'b0000, 32'h0, 4'b0010), 1'b0);

    // Mid-traffic reset with three entries on ch1.
    step(1'b1, mk(4'b0010, 32'h0000_6000, 4'b0000), 1'b0);
    step(1'b1, mk(4'b0010, 32'h0000_6100, 4'b0000), 1'b0);
    step(1'b1, mk(4'b0010, 32'h0000_6200, 4'b0000), 1'b0);
    step(1'b0, mk(4'b0000, 32'h0, 4'b0010), 1'b0);
    step(1'b0, mk(4'b0000, 32'h0, 4'b0000), 1'b0);
    step(1'b1, '{4'b0000, 32'h0, 4'b0000, 4'b1111, 4'b0000, 1'b0, 8'h00, 2'd0}, 1'b1);
    step(1'b1, mk(4'b0000, 32'h0, 4'b0000), 1'b0);
    chk("post_rst_grant_err", 32'(bus.grant_err), 32'h0);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
